// File: rtl/bpm_pkg.sv
// rtl/bpm_pkg.sv - shared pulse-count width, state encoding and saturating increment
//
// Shared by pulse_window_counter and the downstream BPM monitor.
//   COUNT_W   : width of the per-window pulse count
//   COUNT_MAX : saturation ceiling of the pulse count
//   state_e   : window FSM states
//   sat_inc   : add one when requested, sticking at COUNT_MAX instead of wrapping

package bpm_pkg;

    localparam int unsigned        COUNT_W   = 8;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 8'd255;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    function automatic logic [COUNT_W-1:0] sat_inc(
        input logic [COUNT_W-1:0] value,
        input logic               inc
    );
        logic [COUNT_W-1:0] result;
        result = value;
        if (inc && (value != COUNT_MAX)) begin
            result = value + COUNT_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// rtl/pulse_sync_edge.sv - 2-FF synchroniser plus rising-edge detector for the sensor pulse
//
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-low reset, clears all flops
//   din    : raw input, asynchronous to clk
//   edge_o : one-cycle high on each 0->1 transition of the synchronised input

module pulse_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic edge_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Combinational so the edge is visible two clock edges after a well-timed input rise.
    assign edge_o = sync_q & ~prev_q;

endmodule

// File: rtl/pulse_window_counter.sv
// rtl/pulse_window_counter.sv - counts sensor pulses over fixed back-to-back windows
//
// Optional feature macro: PULSE_REFRACTORY_EN (refractory lockout after each counted edge).
//
// Parameters:
//   WINDOW_CYCLES     : clock cycles per measurement window (>= 2)
//   REFRACTORY_CYCLES : lockout cycles after a counted edge (refractory build only)
// Ports:
//   clk           : system clock
//   reset         : asynchronous active-low reset
//   enable        : high runs windows back to back, low idles with timer/acc held at 0
//   pulse_in      : raw sensor pulse, asynchronous to clk
//   pulse_count   : saturated count of the last completed window
//   count_valid   : one-cycle strobe when pulse_count updates
//   overflow      : last completed window saturated
//   window_active : high while counting

module pulse_window_counter
    import bpm_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES     = 10000,
    parameter int unsigned REFRACTORY_CYCLES = 300
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               pulse_in,
    output logic [COUNT_W-1:0] pulse_count,
    output logic               count_valid,
    output logic               overflow,
    output logic               window_active
);

    localparam int unsigned        TIMER_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);

    state_e             state_q;
    logic [TIMER_W-1:0] timer_q;
    logic [COUNT_W-1:0] acc_q;
    logic [COUNT_W-1:0] acc_d;
    logic               sat_q;
    logic               sat_d;
    logic [COUNT_W-1:0] pulse_count_q;
    logic               count_valid_q;
    logic               overflow_q;
    logic               window_active_q;

    logic               edge_det;
    logic               count_edge;
    logic               window_last;

    pulse_sync_edge u_sync_edge (
        .clk    (clk),
        .reset  (reset),
        .din    (pulse_in),
        .edge_o (edge_det)
    );

`ifdef PULSE_REFRACTORY_EN
    localparam int unsigned REFR_W = (REFRACTORY_CYCLES > 0) ? $clog2(REFRACTORY_CYCLES + 1) : 1;

    logic [REFR_W-1:0] refr_q;
    logic [REFR_W-1:0] refr_d;

    // Edges are dropped while the lockout counter is still running.
    assign count_edge = edge_det && (refr_q == '0);

    // The lockout only runs while windows are being counted; it spans window
    // boundaries but is cleared whenever the block drops back to IDLE.
    always_comb begin
        refr_d = refr_q;
        if ((state_q != COUNT) || !enable) begin
            refr_d = '0;
        end else if (count_edge) begin
            refr_d = REFR_W'(REFRACTORY_CYCLES);
        end else if (refr_q != '0) begin
            refr_d = refr_q - REFR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refr_q <= '0;
        end else begin
            refr_q <= refr_d;
        end
    end
`else
    logic unused_refr_cfg;

    assign count_edge      = edge_det;
    assign unused_refr_cfg = ^REFRACTORY_CYCLES;
`endif

    // Accumulator and saturation flag including this cycle's edge; on the closing
    // cycle these are what get published, so a last-cycle edge lands in the old window.
    assign acc_d       = sat_inc(acc_q, count_edge);
    assign sat_d       = sat_q | (count_edge & (acc_q == COUNT_MAX));
    assign window_last = (timer_q == TIMER_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            timer_q         <= '0;
            acc_q           <= '0;
            sat_q           <= 1'b0;
            pulse_count_q   <= '0;
            count_valid_q   <= 1'b0;
            overflow_q      <= 1'b0;
            window_active_q <= 1'b0;
        end else begin
            count_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    acc_q   <= '0;
                    sat_q   <= 1'b0;
                    if (enable) begin
                        state_q         <= COUNT;
                        window_active_q <= 1'b1;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        // Abort: partial window discarded, published results untouched.
                        state_q         <= IDLE;
                        window_active_q <= 1'b0;
                        timer_q         <= '0;
                        acc_q           <= '0;
                        sat_q           <= 1'b0;
                    end else if (window_last) begin
                        // Publish and restart immediately so windows abut with no gap.
                        pulse_count_q <= acc_d;
                        overflow_q    <= sat_d;
                        count_valid_q <= 1'b1;
                        timer_q       <= '0;
                        acc_q         <= '0;
                        sat_q         <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                        acc_q   <= acc_d;
                        sat_q   <= sat_d;
                    end
                end
                default: begin
                    state_q         <= IDLE;
                    window_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_count   = pulse_count_q;
    assign count_valid   = count_valid_q;
    assign overflow      = overflow_q;
    assign window_active = window_active_q;

endmodule

// File: tb/tb_pulse_window_counter.sv
// tb/tb_pulse_window_counter.sv - directed self-checking bench for pulse_window_counter

module tb_pulse_window_counter;
    import bpm_pkg::*;

    localparam int unsigned WIN     = 100;
    localparam int unsigned REFR    = 5;
    localparam int unsigned WIN_SAT = 1100;

`ifdef PULSE_REFRACTORY_EN
    localparam int EXP_STREAM  = 13;
    localparam int EXP_SAT     = 138;
    localparam int EXP_SAT_OVF = 0;
    localparam int EXP_TEN     = 5;
`else
    localparam int EXP_STREAM  = 25;
    localparam int EXP_SAT     = 255;
    localparam int EXP_SAT_OVF = 1;
    localparam int EXP_TEN     = 10;
`endif

    logic               clk;
    logic               reset;
    logic               enable;
    logic               enable_sat;
    logic               pulse_in;

    logic [COUNT_W-1:0] pulse_count;
    logic               count_valid;
    logic               overflow;
    logic               window_active;

    logic [COUNT_W-1:0] pulse_count_sat;
    logic               count_valid_sat;
    logic               overflow_sat;
    logic               window_active_sat;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int strobe_q[$];

    pulse_window_counter #(
        .WINDOW_CYCLES     (WIN),
        .REFRACTORY_CYCLES (REFR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .pulse_in      (pulse_in),
        .pulse_count   (pulse_count),
        .count_valid   (count_valid),
        .overflow      (overflow),
        .window_active (window_active)
    );

    pulse_window_counter #(
        .WINDOW_CYCLES     (WIN_SAT),
        .REFRACTORY_CYCLES (REFR)
    ) dut_sat (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable_sat),
        .pulse_in      (pulse_in),
        .pulse_count   (pulse_count_sat),
        .count_valid   (count_valid_sat),
        .overflow      (overflow_sat),
        .window_active (window_active_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (count_valid === 1'b1) strobe_q.push_back(cyc);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic pulse(input int hi, input int lo);
        pulse_in = 1'b1;
        repeat (hi) step();
        pulse_in = 1'b0;
        repeat (lo) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int e;
        int r;
        int x;
        int s;
        int nb;

        reset      = 1'b0;
        enable     = 1'b0;
        enable_sat = 1'b0;
        pulse_in   = 1'b0;

        // Reset state
        step();
        step();
        check("rst_pulse_count", pulse_count, 0);
        check("rst_count_valid", count_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_window_active", window_active, 0);
        check("rst_sat_pulse_count", pulse_count_sat, 0);
        reset = 1'b1;
        step();
        step();

        // First window: 12 clean 4/4 pulses, strobe 101 cycles after enable
        enable = 1'b1;
        e = cyc;
        step();
        check("en_window_active", window_active, 1);
        repeat (12) pulse(4, 4);
        run_to(e + 100);
        check("w1_no_early_strobe", strobe_q.size(), 0);
        step();
        check("w1_count_valid", count_valid, 1);
        check("w1_pulse_count", pulse_count, 12);
        check("w1_overflow", overflow, 0);
        step();
        check("w1_strobe_one_cycle", count_valid, 0);
        check("w1_count_held", pulse_count, 12);

        // Empty window, strobe spacing
        run_to(e + 201);
        check("w2_count_valid", count_valid, 1);
        check("w2_pulse_count", pulse_count, 0);
        check("w2_strobe_spacing", (strobe_q.size() >= 2) ? strobe_q[1] - strobe_q[0] : -1, WIN);

        // Edge on timer = 99 counts in the closing window
        run_to(e + 298);
        pulse_in = 1'b1;
        run_to(e + 301);
        check("w3_count_valid", count_valid, 1);
        check("w3_last_cycle_edge", pulse_count, 1);
        step();
        pulse_in = 1'b0;

        // Edge on timer = 0 counts in the new window
        run_to(e + 399);
        pulse_in = 1'b1;
        run_to(e + 401);
        check("w4_count_valid", count_valid, 1);
        check("w4_first_cycle_edge_excluded", pulse_count, 0);
        run_to(e + 403);
        pulse_in = 1'b0;
        run_to(e + 501);
        check("w5_count_valid", count_valid, 1);
        check("w5_first_cycle_edge_counted", pulse_count, 1);

        // Abort at timer = 50 with 5 pulses accumulated
        run_to(e + 502);
        repeat (5) pulse(4, 4);
        run_to(e + 551);
        enable = 1'b0;
        step();
        check("abort_window_active", window_active, 0);
        check("abort_count_valid", count_valid, 0);
        check("abort_count_held", pulse_count, 1);
        check("abort_overflow_held", overflow, 0);
        run_to(e + 620);
        check("abort_no_strobe", strobe_q.size(), 5);
        check("abort_count_still_held", pulse_count, 1);

        // Reset mid-window with 7 pulses accumulated
        enable = 1'b1;
        r = cyc;
        step();
        check("rst2_window_active_before", window_active, 1);
        repeat (7) pulse(4, 4);
        run_to(r + 60);
        reset = 1'b0;
        #1;
        check("rst2_pulse_count", pulse_count, 0);
        check("rst2_count_valid", count_valid, 0);
        check("rst2_overflow", overflow, 0);
        check("rst2_window_active", window_active, 0);
        step();
        step();
        reset = 1'b1;
        x = cyc;
        nb = strobe_q.size();
        run_to(x + 100);
        check("rst2_no_early_strobe", strobe_q.size(), nb);
        step();
        check("rst2_count_valid_101", count_valid, 1);
        check("rst2_acc_cleared", pulse_count, 0);

        // Continuous 2/2 stream: 100-cycle window and saturating 1100-cycle window
        s = cyc;
        enable_sat = 1'b1;
        for (int k = 0; k < 1200; k++) begin
            pulse_in = ((k % 4) < 2);
            step();
            if (cyc == s + 100) begin
                check("stream_count_valid", count_valid, 1);
                check("stream_pulse_count", pulse_count, EXP_STREAM);
                check("stream_overflow", overflow, 0);
            end
            if (cyc == s + 1101) begin
                check("sat_count_valid", count_valid_sat, 1);
                check("sat_pulse_count", pulse_count_sat, EXP_SAT);
                check("sat_overflow", overflow_sat, EXP_SAT_OVF);
            end
        end
        pulse_in   = 1'b0;
        enable_sat = 1'b0;

        // Ten pulses every 4 cycles (refractory drops every second one)
        run_to(s + 1210);
        repeat (10) pulse(2, 2);
        run_to(s + 1300);
        check("ten_count_valid", count_valid, 1);
        check("ten_pulse_count", pulse_count, EXP_TEN);
        check("ten_overflow", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
